// File: rtl/canny_pkg.sv
// Shared constants and FSM state type for the canny_edge frame feeder and its consumers.
package canny_pkg;

    localparam int unsigned IMG_W        = 256;
    localparam int unsigned IMG_H        = 256;
    localparam int unsigned BURST_LINES  = 4;
    localparam int unsigned BURST_LEN    = BURST_LINES * IMG_W;
    localparam int unsigned FLUSH_BURSTS = 2;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_INTR,
        FLUSH_WAIT,
        FLUSH_SEND,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/canny_frame_feeder_if.sv
// Upstream 8-bit AXI-Stream pixel channel feeding canny_frame_feeder.
interface canny_frame_feeder_if;

    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;

    modport master (output s_axis_tdata, output s_axis_tvalid, input s_axis_tready);
    modport slave  (input s_axis_tdata, input s_axis_tvalid, output s_axis_tready);

endinterface

// File: rtl/canny_intr_latch.sv
// Rising-edge detector on the canny_edge interrupt level with a sticky pending flag.
module canny_intr_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic interrupt,
    input  logic enable,
    input  logic consume,
    output logic pend
);

    logic intr_q;
    logic rise;

    assign rise = interrupt && !intr_q;

    // Consume clears the old flag; an edge in the same cycle re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            intr_q <= interrupt;
            pend   <= (pend && !consume) || (rise && enable);
        end
    end

endmodule

// File: rtl/canny_frame_feeder.sv
// Streams one frame into canny_edge in interrupt-paced bursts, then appends zero bursts to drain it.
module canny_frame_feeder #(
    parameter int unsigned IMG_W        = canny_pkg::IMG_W,
    parameter int unsigned IMG_H        = canny_pkg::IMG_H,
    parameter int unsigned BURST_LINES  = canny_pkg::BURST_LINES,
    parameter int unsigned FLUSH_BURSTS = canny_pkg::FLUSH_BURSTS
) (
    input  logic                axi_clk,
    input  logic                axi_rst_n,
    input  logic                frame_start,
    canny_frame_feeder_if.slave s_axis,
    input  logic                dut_ready,
    output logic [7:0]          pixel_in,
    output logic                pixel_in_valid,
    input  logic                interrupt,
    output logic                busy,
    output logic                frame_done
);

    import canny_pkg::*;

    localparam int unsigned BLEN   = BURST_LINES * IMG_W;
    localparam int unsigned TOTAL  = IMG_W * IMG_H;
    localparam int          BEAT_W = $clog2(BLEN) + 1;
    localparam int          PIX_W  = $clog2(TOTAL) + 1;
    localparam int          FL_W   = $clog2(FLUSH_BURSTS) + 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLEN - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(TOTAL - 1);
    localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_BURSTS - 1);

    feeder_state_t      state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [PIX_W-1:0]   pix_total;
    logic [FL_W-1:0]    burst_cnt;
    logic               intr_pend;
    logic               consume;
    logic               beat;

    assign s_axis.s_axis_tready = (state == SEND) && dut_ready;
    assign beat                 = s_axis.s_axis_tvalid && s_axis.s_axis_tready;
    assign busy                 = (state != IDLE);
    assign frame_done           = (state == DONE);

    // Starting a frame also discards any interrupt left over from the previous one.
    assign consume = ((state == IDLE) && frame_start) ||
                     (((state == WAIT_INTR) || (state == FLUSH_WAIT)) && intr_pend);

    canny_intr_latch u_intr_latch (
        .clk       (axi_clk),
        .rst_n     (axi_rst_n),
        .interrupt (interrupt),
        .enable    (busy),
        .consume   (consume),
        .pend      (intr_pend)
    );

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            pix_total      <= '0;
            burst_cnt      <= '0;
            pixel_in       <= '0;
            pixel_in_valid <= 1'b0;
        end else begin
            pixel_in_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state     <= SEND;
                        beat_cnt  <= '0;
                        pix_total <= '0;
                        burst_cnt <= '0;
                    end
                end
                SEND: begin
                    if (beat) begin
                        pixel_in       <= s_axis.s_axis_tdata;
                        pixel_in_valid <= 1'b1;
                        pix_total      <= pix_total + 1'b1;
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            state    <= (pix_total == PIX_LAST) ? FLUSH_WAIT : WAIT_INTR;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                WAIT_INTR: begin
                    if (intr_pend) state <= SEND;
                end
                FLUSH_WAIT: begin
                    if (intr_pend) state <= FLUSH_SEND;
                end
                FLUSH_SEND: begin
                    if (dut_ready) begin
                        pixel_in       <= '0;
                        pixel_in_valid <= 1'b1;
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt  <= '0;
                            burst_cnt <= burst_cnt + 1'b1;
                            state     <= (burst_cnt == FL_LAST) ? DONE : FLUSH_WAIT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_canny_frame_feeder.sv
// Randomised bench for canny_frame_feeder on an 8x8 frame, 2-line bursts, 2 flush bursts.
module tb_canny_frame_feeder;

    localparam int BLEN = 16;
    localparam int NPIX = 64;
    localparam int NOUT = 96;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       dut_ready = 1'b0;
    logic       interrupt = 1'b0;
    logic [7:0] pixel_in;
    logic       pixel_in_valid;
    logic       busy;
    logic       frame_done;

    canny_frame_feeder_if axis ();

    always #5 clk = ~clk;

    canny_frame_feeder #(
        .IMG_W        (8),
        .IMG_H        (8),
        .BURST_LINES  (2),
        .FLUSH_BURSTS (2)
    ) dut (
        .axi_clk        (clk),
        .axi_rst_n      (rst_n),
        .frame_start    (frame_start),
        .s_axis         (axis),
        .dut_ready      (dut_ready),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .interrupt      (interrupt),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] src[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         strobe_cyc[$];
    int         src_idx = 0;
    int         strobe_cnt = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         fcyc = 0;
    int         vmode = 0;
    int         rmode = 0;
    int         intr_timer = -1;
    int         intr_hold = 0;
    int         intr_delay = 20;
    bit         intr_auto = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bit v;
        case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = $urandom_range(0, 3) != 0;
        endcase
        axis.s_axis_tvalid = v && (src_idx < src.size());
        axis.s_axis_tdata  = (src_idx < src.size()) ? src[src_idx] : 8'h00;
        case (rmode)
            0:       dut_ready = 1'b1;
            1:       dut_ready = !(fcyc >= 5 && fcyc <= 9);
            default: dut_ready = $urandom_range(0, 4) != 0;
        endcase
        if (intr_timer == 0) begin
            intr_hold  = 2;
            intr_timer = -1;
        end else if (intr_timer > 0) begin
            intr_timer--;
        end
        interrupt = (intr_hold > 0);
        if (intr_hold > 0) intr_hold--;
    endtask

    // Sample on the falling edge, then advance the source and drive on the rising edge.
    task automatic tick();
        bit b;
        @(negedge clk);
        if (pixel_in_valid) begin
            got_q.push_back(pixel_in);
            strobe_cyc.push_back(cyc);
            strobe_cnt++;
            if (intr_auto && (strobe_cnt % BLEN) == 0) intr_timer = intr_delay;
        end
        if (frame_done) done_cnt++;
        if (!dut_ready) check("tready_gated", 32'(axis.s_axis_tready), 0);
        b = axis.s_axis_tvalid && axis.s_axis_tready;
        @(posedge clk);
        #1;
        if (b) src_idx++;
        cyc++;
        fcyc++;
        drive();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        intr_timer = 0;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, strobe_cnt, n);
    endtask

    task automatic start_frame(input bit ramp, input int vm, input int rm);
        src.delete();
        exp_q.delete();
        got_q.delete();
        strobe_cyc.delete();
        for (int i = 0; i < NPIX; i++) src.push_back(ramp ? 8'(i) : 8'($urandom));
        foreach (src[i]) exp_q.push_back(src[i]);
        for (int i = 0; i < NOUT - NPIX; i++) exp_q.push_back(8'h00);
        src_idx    = 0;
        strobe_cnt = 0;
        done_cnt   = 0;
        vmode      = vm;
        rmode      = rm;
        fcyc       = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int k = 0;
        int n;
        while (done_cnt == 0 && k < 200) begin
            tick();
            k++;
        end
        idle(40);
        check({tag, "_strobes"}, got_q.size(), NOUT);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_pixel"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        drive();
        rst_n = 1'b0;
        idle(3);
        check("rst_valid", 32'(pixel_in_valid), 0);
        check("rst_pixel", 32'(pixel_in), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_tready", 32'(axis.s_axis_tready), 0);
        rst_n = 1'b1;
        idle(3);

        // Ramp frame, no stalls
        intr_auto = 1'b1;
        start_frame(1'b1, 0, 0);
        run_until(NOUT, 3000, "s1_reach");
        finish_frame("s1");

        // Toggling tvalid plus a dut_ready hole in the first burst
        start_frame(1'b1, 1, 1);
        run_until(NOUT, 3000, "s2_reach");
        finish_frame("s2");

        // Random data with random source and sink stalls
        start_frame(1'b0, 2, 2);
        run_until(NOUT, 5000, "s2r_reach");
        finish_frame("s2r");

        // Interrupts delivered while a burst is still streaming
        intr_auto = 1'b0;
        start_frame(1'b0, 0, 0);
        run_until(BLEN, 200, "s3_b1");
        idle(3);
        pulse();
        run_until(24, 200, "s3_mid_b2");
        pulse();
        run_until(33, 200, "s3_b3_start");
        if (strobe_cyc.size() >= 33) check("s3_resume_gap", strobe_cyc[32] - strobe_cyc[31], 2);
        run_until(36, 200, "s3_mid_b3");
        pulse();
        idle(4);
        pulse();
        run_until(NPIX, 200, "s3_b4");
        idle(100);
        check("s3_single_release", strobe_cnt, NPIX);
        check("s3_hold_valid", 32'(pixel_in_valid), 0);
        pulse();
        run_until(80, 200, "s3_flush1");
        idle(3);
        pulse();
        run_until(NOUT, 200, "s3_flush2");
        finish_frame("s3");

        // Missing interrupt stalls indefinitely
        start_frame(1'b0, 0, 0);
        run_until(BLEN, 200, "s4_b1");
        idle(1000);
        check("s4_stalled", strobe_cnt, BLEN);
        check("s4_tready", 32'(axis.s_axis_tready), 0);
        check("s4_valid", 32'(pixel_in_valid), 0);
        check("s4_busy", 32'(busy), 1);
        intr_auto = 1'b1;
        pulse();
        run_until(NOUT, 3000, "s4_reach");
        finish_frame("s4");

        // Asynchronous reset in the middle of burst 3
        start_frame(1'b0, 0, 0);
        run_until(40, 1000, "s5_mid_b3");
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", 32'(pixel_in_valid), 0);
        check("s5_rst_busy", 32'(busy), 0);
        check("s5_rst_tready", 32'(axis.s_axis_tready), 0);
        intr_timer = -1;
        intr_hold  = 0;
        interrupt  = 1'b0;
        idle(3);
        check("s5_no_done", done_cnt, 0);
        rst_n = 1'b1;
        idle(3);
        start_frame(1'b0, 0, 0);
        run_until(NOUT, 3000, "s5_reach");
        finish_frame("s5");

        // Spurious frame_start during SEND and FLUSH_SEND
        start_frame(1'b0, 0, 0);
        run_until(10, 200, "s6_send");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        run_until(70, 1000, "s6_flush");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        run_until(NOUT, 1000, "s6_reach");
        finish_frame("s6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
